// File: rtl/simd_pkg.sv
// Width constants and state encoding shared by the SIMD memory-stage
// scatter (vec_unpack) and gather paths.
package simd_pkg;

  localparam int LANES  = 8;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 16;
  localparam int VEC_W  = LANES * DATA_W;
  localparam int LANE_W = $clog2(LANES);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    CAP,
    WR,
    DONE
  } unpack_state_t;

endpackage

// File: rtl/vec_lane_sel.sv
// Combinational LANES:1 mux picking one DATA_W lane out of a packed vector.
// Lane 0 is the least significant slice.
module vec_lane_sel
  import simd_pkg::*;
(
  input  logic [VEC_W-1:0]  vec,
  input  logic [LANE_W-1:0] sel,
  output logic [DATA_W-1:0] lane
);

  always_comb begin
    lane = '0;
    for (int i = 0; i < LANES; i++) begin
      if (sel == LANE_W'(i)) lane = vec[i*DATA_W +: DATA_W];
    end
  end

endmodule

// File: rtl/vec_unpack.sv
// Vector-to-scalar unpack engine: reads one vector from the vector RAM and
// writes its lanes to consecutive scalar RAM words, yielding to core writes.
module vec_unpack
  import simd_pkg::*;
#(
  parameter int RD_LAT = 1  // synchronous read latency, must be >= 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic [ADDR_W-1:0]   vaddr_i,
  input  logic [ADDR_W-1:0]   saddr_i,
  input  logic                core_we_i,
  output logic [ADDR_W-1:0]   vec_rd_addr_o,
  output logic                vec_rd_en_o,
  input  logic [VEC_W-1:0]    vec_rd_data_i,
  output logic                scal_we_o,
  output logic [ADDR_W-1:0]   scal_addr_o,
  output logic [DATA_W-1:0]   scal_data_o,
  output logic                busy_o,
  output logic                done_o,
  output unpack_state_t       state_o
);

  localparam int WAIT_W = 8;

  // Handshake: start_i is a request taken only while busy_o=0 (state IDLE);
  // it is dropped, never queued, while busy. done_o pulses once per accepted
  // start, and busy_o falls in the cycle after that pulse.

  unpack_state_t       state, state_d;
  logic [ADDR_W-1:0]   vaddr_q, vaddr_d;
  logic [ADDR_W-1:0]   saddr_q, saddr_d;
  logic [VEC_W-1:0]    hold_q, hold_d;
  logic [LANE_W-1:0]   lane_q, lane_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [DATA_W-1:0]   lane_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      vaddr_q <= '0;
      saddr_q <= '0;
      hold_q  <= '0;
      lane_q  <= '0;
      wait_q  <= '0;
    end else begin
      state   <= state_d;
      vaddr_q <= vaddr_d;
      saddr_q <= saddr_d;
      hold_q  <= hold_d;
      lane_q  <= lane_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state;
    vaddr_d = vaddr_q;
    saddr_d = saddr_q;
    hold_d  = hold_q;
    lane_d  = lane_q;
    wait_d  = wait_q;
    case (state)
      IDLE: begin
        if (start_i) begin
          vaddr_d = vaddr_i;
          saddr_d = saddr_i;
          lane_d  = '0;
          wait_d  = '0;
          state_d = RD;
        end
      end
      RD: begin
        if (wait_q == WAIT_W'(RD_LAT - 1)) state_d = CAP;
        else wait_d = wait_q + 8'd1;
      end
      CAP: begin
        hold_d  = vec_rd_data_i;
        state_d = WR;
      end
      WR: begin
        // A core write owns the port this cycle: hold the lane index.
        if (!core_we_i) begin
          lane_d = lane_q + 1'b1;
          if (lane_q == LANE_W'(LANES - 1)) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  vec_lane_sel u_lane_sel (
    .vec  (hold_q),
    .sel  (lane_q),
    .lane (lane_data)
  );

  assign busy_o        = (state != IDLE);
  assign done_o        = (state == DONE);
  assign vec_rd_en_o   = (state == RD);
  assign vec_rd_addr_o = vaddr_q;
  assign scal_we_o     = (state == WR) && !core_we_i;
  assign scal_addr_o   = saddr_q + ADDR_W'(lane_q);
  assign scal_data_o   = lane_data;
  assign state_o       = state;

endmodule
